serial_paralelo: RTL and testbench

SERIAL_PARALELO -- requirements
Module: serial_paralelo

---
 rtl/serial_paralelo.sv | 97 +++++++++
 tb/tb_serial_paralelo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo.sv
// Dibit-to-byte deserializer: hunts for the COMMA byte at any dibit offset, confirms
// alignment over BC_COUNT consecutive aligned commas, then emits {valid, data} per byte.
module serial_paralelo #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int         BC_COUNT = 4
) (
    input  logic       clk16f,
    input  logic       reset_L,
    input  logic [1:0] serial,
    output logic [8:0] paralelo_out,
    output logic       active
);

    localparam int CW = $clog2(BC_COUNT + 1);

    typedef enum logic [1:0] {
        BUSCANDO,
        ALINEANDO,
        SINCRONIZADO
    } state_t;

    state_t        state, state_next;
    // Only the six most recent bits are ever needed to form the candidate byte.
    logic [5:0]    shreg;
    logic [7:0]    cand;
    logic [1:0]    fase, fase_next;
    logic [CW-1:0] bc_cnt, bc_cnt_next, bc_inc;
    logic [8:0]    paralelo_next;
    logic          active_next;
    logic          boundary;
    logic          is_comma;

    assign cand     = {shreg, serial};
    assign is_comma = (cand == COMMA);
    assign boundary = (fase == 2'd3);
    assign bc_inc   = bc_cnt + CW'(1);

    always_ff @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            state        <= BUSCANDO;
            shreg        <= '0;
            fase         <= '0;
            bc_cnt       <= '0;
            paralelo_out <= '0;
            active       <= 1'b0;
        end else begin
            state        <= state_next;
            shreg        <= cand[5:0];
            fase         <= fase_next;
            bc_cnt       <= bc_cnt_next;
            paralelo_out <= paralelo_next;
            active       <= active_next;
        end
    end

    always_comb begin
        state_next    = state;
        fase_next     = fase + 2'd1;
        bc_cnt_next   = bc_cnt;
        paralelo_next = paralelo_out;
        active_next   = active;
        case (state)
            BUSCANDO: begin
                // Any dibit offset may start a byte; the comma fixes the phase.
                if (is_comma) begin
                    fase_next   = 2'd0;
                    bc_cnt_next = CW'(1);
                    state_next  = ALINEANDO;
                end
            end
            ALINEANDO: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_next = bc_inc;
                        if (bc_inc == CW'(BC_COUNT)) begin
                            state_next  = SINCRONIZADO;
                            active_next = 1'b1;
                        end
                    end else begin
                        bc_cnt_next = '0;
                        state_next  = BUSCANDO;
                    end
                end
            end
            SINCRONIZADO: begin
                // Commas are idle fill and are reported as an invalid word.
                if (boundary) begin
                    paralelo_next = is_comma ? 9'h000 : {1'b1, cand};
                end
            end
            default: begin
                state_next = BUSCANDO;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: a replay model rebuilds the expected outputs from the
// whole dibit history since reset; directed checks pin the model with literal values.
module tb_serial_paralelo;

    localparam logic [7:0] COMMA    = 8'hBC;
    localparam int         BC_COUNT = 4;

    logic       clk16f  = 1'b0;
    logic       reset_L = 1'b0;
    logic [1:0] serial  = 2'b00;
    logic [8:0] paralelo_out;
    logic       active;

    int tests = 0;
    int fails = 0;
    bit running = 1'b0;

    logic [1:0] hist [0:1023];
    int         hist_len = 0;

    always #5 clk16f = ~clk16f;

    serial_paralelo #(
        .COMMA   (COMMA),
        .BC_COUNT(BC_COUNT)
    ) dut (
        .clk16f      (clk16f),
        .reset_L     (reset_L),
        .serial      (serial),
        .paralelo_out(paralelo_out),
        .active      (active)
    );

    // Byte formed by the four dibits ending at edge e (1-based); zeros before reset release.
    function automatic logic [7:0] win(int e);
        logic [7:0] w;
        w = '0;
        for (int k = 3; k >= 0; k--) begin
            w = {w[5:0], (e - k >= 1) ? hist[e - k - 1] : 2'b00};
        end
        return w;
    endfunction

    function automatic void model(output logic act, output logic [8:0] po);
        int len, e, b, cnt, sync_edge, k;
        bit done, failed;
        logic [7:0] w;
        len       = hist_len;
        e         = 1;
        b         = 0;
        sync_edge = 0;
        done      = 1'b0;
        while (!done && e <= len) begin
            if (win(e) == COMMA) begin
                cnt    = 1;
                b      = e + 4;
                failed = 1'b0;
                while (!done && !failed && b <= len) begin
                    if (win(b) == COMMA) begin
                        cnt++;
                        if (cnt >= BC_COUNT) begin
                            sync_edge = b;
                            done      = 1'b1;
                        end else begin
                            b += 4;
                        end
                    end else begin
                        failed = 1'b1;
                    end
                end
                if (failed) e = b + 1;
                else        done = 1'b1;
            end else begin
                e++;
            end
        end
        act = (sync_edge > 0);
        po  = 9'h000;
        if (act) begin
            k = (len - sync_edge) / 4;
            if (k >= 1) begin
                w  = win(sync_edge + 4 * k);
                po = (w == COMMA) ? 9'h000 : {1'b1, w};
            end
        end
    endfunction

    always @(negedge clk16f) begin
        logic       ea;
        logic [8:0] ep;
        if (running) begin
            model(ea, ep);
            tests++;
            if (paralelo_out !== ep) begin
                fails++;
                $display("FAIL model_po: got %h expected %h (edge %0d)", paralelo_out, ep, hist_len);
            end
            tests++;
            if (active !== ea) begin
                fails++;
                $display("FAIL model_active: got %b expected %b (edge %0d)", active, ea, hist_len);
            end
        end
    end

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("[TB] %s ok: %h", name, got);
        end
    endtask

    task automatic send_dibit(input logic [1:0] d);
        serial = d;
        @(posedge clk16f);
        if (hist_len < 1024) begin
            hist[hist_len] = d;
            hist_len++;
        end
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 3; i >= 0; i--) send_dibit(b[2*i+1 -: 2]);
    endtask

    // Stand-in for the paralelo-serial stage: invalid words go out as COMMA.
    task automatic send_word(input logic [8:0] w);
        send_byte(w[8] ? w[7:0] : COMMA);
    endtask

    task automatic pulse_reset();
        #2 reset_L = 1'b0;
        hist_len = 0;
        #1;
        chk("rst_po", paralelo_out, 9'h000);
        chk("rst_active", 9'(active), 9'h000);
        #2 reset_L = 1'b1;
    endtask

    initial begin
        running = 1'b1;
        repeat (3) @(posedge clk16f);
        #1;
        chk("reset_po", paralelo_out, 9'h000);
        chk("reset_active", 9'(active), 9'h000);
        #2 reset_L = 1'b1;

        // Four aligned commas straight out of reset.
        repeat (3) send_byte(COMMA);
        send_dibit(2'b10); send_dibit(2'b11); send_dibit(2'b11);
        chk("pre_sync_active", 9'(active), 9'h000);
        send_dibit(2'b00);
        chk("sync_active", 9'(active), 9'h001);
        chk("sync_po", paralelo_out, 9'h000);

        // Data byte 0x16, held until the next boundary, then a comma.
        send_dibit(2'b00); send_dibit(2'b01); send_dibit(2'b01);
        chk("mid_byte_po", paralelo_out, 9'h000);
        send_dibit(2'b10);
        chk("data16_po", paralelo_out, 9'h116);
        send_dibit(2'b10); send_dibit(2'b11); send_dibit(2'b11);
        chk("hold16_po", paralelo_out, 9'h116);
        send_dibit(2'b00);
        chk("comma_po", paralelo_out, 9'h000);
        send_byte(8'hA5);
        chk("dataA5_po", paralelo_out, 9'h1A5);

        // One stray dibit shifts alignment by one position.
        pulse_reset();
        send_dibit(2'b01);
        repeat (3) send_byte(COMMA);
        chk("offset_pre_active", 9'(active), 9'h000);
        send_byte(COMMA);
        chk("offset_active", 9'(active), 9'h001);
        send_byte(8'hA5);
        chk("offset_A5_po", paralelo_out, 9'h1A5);

        // Interrupted comma run must restart the count.
        pulse_reset();
        repeat (3) send_byte(COMMA);
        send_byte(8'h55);
        chk("broken_active", 9'(active), 9'h000);
        chk("broken_po", paralelo_out, 9'h000);
        repeat (3) send_byte(COMMA);
        chk("rerun3_active", 9'(active), 9'h000);
        send_byte(COMMA);
        chk("rerun4_active", 9'(active), 9'h001);
        chk("rerun4_po", paralelo_out, 9'h000);

        // Reset mid-byte while synchronized, then resync.
        send_byte(8'h3C);
        chk("pre_rst_po", paralelo_out, 9'h13C);
        send_dibit(2'b11); send_dibit(2'b01);
        pulse_reset();
        repeat (4) send_byte(COMMA);
        chk("resync_active", 9'(active), 9'h001);
        send_byte(8'h3C);
        chk("resync_po", paralelo_out, 9'h13C);

        // Words passed through the serializer stand-in.
        send_word(9'h1F0);
        chk("chain_1F0", paralelo_out, 9'h1F0);
        send_word(9'h0AB);
        chk("chain_0AB", paralelo_out, 9'h000);
        send_word(9'h17E);
        chk("chain_17E", paralelo_out, 9'h17E);

        @(negedge clk16f);
        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
